matrix_store_writer: RTL and testbench

Downstream consumer of the compute subsystem's matrix-write interface. Accepts a result-matrix header (slot ID, rows, cols, name) and a stream of element words, and writes them into the shared matrix BRAM slot at base = id*BLOCK_SIZE. Element data is written first. Metadata is written last, so a scanner never sees a valid header over partial data. Signals completion or error to the producer.

---
 rtl/matrix_store_pkg.sv | 29 ++
 rtl/matrix_store_writer.sv | 192 +++++++++++++++++++
 tb/tb_matrix_store_writer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_store_pkg.sv
// Shared definitions for the matrix slot BRAM layout.
// Contents:
//   writer_state_t  - store-writer FSM states
//   META_WORDS      - header words at the start of every slot
//   DATA_OFFSET     - offset of the first element word within a slot
//   SLOT_BLOCK_SIZE - default words per slot (shared with scanner and reader)
//   pack_meta()     - builds header word 0 from the matrix dimensions
package matrix_store_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StStream,
    StMeta0,
    StMeta1,
    StDone,
    StErr
  } writer_state_t;

  localparam int unsigned META_WORDS      = 2;
  localparam int unsigned DATA_OFFSET     = 2;
  localparam int unsigned SLOT_BLOCK_SIZE = 1152;

  // Header word 0: rows in [31:24], cols in [23:16], low half reserved as zero.
  function automatic logic [31:0] pack_meta(input logic [7:0] rows, input logic [7:0] cols);
    return {rows, cols, 16'd0};
  endfunction

endpackage

// File: rtl/matrix_store_writer.sv
// Matrix store writer: accepts a result-matrix header and a row-major stream of
// element words from the compute subsystem and writes them into the matrix BRAM
// slot at base = id*BLOCK_SIZE. Elements go to base+2.., then the two header
// words (base+0, base+1) are written last so a scanner never sees a valid header
// over partial data.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   write_request/write_ready - header handshake (sampled only when ready)
//   write_matrix_id/rows/cols - destination slot and dimensions
//   write_name[0:7]           - ASCII name; only bytes 0..3 are stored
//   write_data/_valid         - element stream, one word per valid cycle
//   write_done/write_error    - one-cycle completion / reject-or-abort pulses
//   busy                      - high whenever not idle
//   bram_we/addr/din          - registered BRAM write port
module matrix_store_writer
  import matrix_store_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE     = SLOT_BLOCK_SIZE,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 14,
  parameter int unsigned NUM_SLOTS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_request,
  output logic                  write_ready,
  input  logic [2:0]            write_matrix_id,
  input  logic [7:0]            write_rows,
  input  logic [7:0]            write_cols,
  input  logic [7:0]            write_name [0:7],
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_data_valid,
  output logic                  write_done,
  output logic                  write_error,
  output logic                  busy,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din
);

  localparam int unsigned TimerWidth = $clog2(TIMEOUT_CYCLES + 1);

  writer_state_t state_q, state_d;

  logic [2:0]            id_q, id_d;
  logic [7:0]            rows_q, rows_d;
  logic [7:0]            cols_q, cols_d;
  logic [31:0]           name_q, name_d;
  logic [15:0]           total_q, total_d;
  logic [15:0]           count_q, count_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [TimerWidth-1:0] idle_q, idle_d;
  logic                  bram_we_q, bram_we_d;
  logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_WIDTH-1:0] bram_din_q, bram_din_d;

  logic                  hdr_bad;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] base_calc;
  logic [ADDR_WIDTH-1:0] base_now;

  // Name bytes 4..7 are part of the interface but are not stored.
  logic unused_name;
  assign unused_name = ^{write_name[4], write_name[5], write_name[6], write_name[7]};

  // Constant-coefficient multiply; the result always fits ADDR_WIDTH for valid ids.
  assign base_calc = ADDR_WIDTH'(32'(id_q) * BLOCK_SIZE);

  assign hdr_bad = (rows_q == 8'd0) || (cols_q == 8'd0) ||
                   (32'(id_q) >= NUM_SLOTS) ||
                   (32'(total_q) > BLOCK_SIZE - META_WORDS);

  // base_q is only loaded at the end of CHECK, so a word accepted during CHECK
  // uses the freshly computed base.
  assign base_now = (state_q == StCheck) ? base_calc : base_q;

  assign accept = write_data_valid &&
                  ((state_q == StStream) || ((state_q == StCheck) && !hdr_bad));

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    name_d      = name_q;
    total_d     = total_q;
    count_d     = count_q;
    base_d      = base_q;
    idle_d      = idle_q;
    bram_we_d   = 1'b0;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;

    unique case (state_q)
      StIdle: begin
        if (write_request) begin
          id_d    = write_matrix_id;
          rows_d  = write_rows;
          cols_d  = write_cols;
          name_d  = {write_name[0], write_name[1], write_name[2], write_name[3]};
          total_d = 16'(write_rows) * 16'(write_cols);
          count_d = '0;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (hdr_bad) begin
          state_d = StErr;
        end else begin
          base_d  = base_calc;
          idle_d  = '0;
          state_d = StStream;
        end
      end
      StStream: begin
        if (write_data_valid) begin
          idle_d = '0;
        end else if (32'(idle_q) + 32'd1 == TIMEOUT_CYCLES) begin
          state_d = StErr;
        end else begin
          idle_d = idle_q + TimerWidth'(1);
        end
      end
      StMeta0: begin
        bram_we_d   = 1'b1;
        bram_addr_d = base_q;
        bram_din_d  = DATA_WIDTH'(pack_meta(rows_q, cols_q));
        state_d     = StMeta1;
      end
      StMeta1: begin
        bram_we_d   = 1'b1;
        bram_addr_d = base_q + ADDR_WIDTH'(1);
        bram_din_d  = DATA_WIDTH'(name_q);
        state_d     = StDone;
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Element write shared by CHECK and STREAM; the last word jumps to metadata.
    if (accept) begin
      bram_we_d   = 1'b1;
      bram_addr_d = base_now + ADDR_WIDTH'(DATA_OFFSET) + ADDR_WIDTH'(count_q);
      bram_din_d  = write_data;
      count_d     = count_q + 16'd1;
      if (count_q + 16'd1 == total_q) begin
        state_d = StMeta0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      id_q        <= '0;
      rows_q      <= '0;
      cols_q      <= '0;
      name_q      <= '0;
      total_q     <= '0;
      count_q     <= '0;
      base_q      <= '0;
      idle_q      <= '0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      name_q      <= name_d;
      total_q     <= total_d;
      count_q     <= count_d;
      base_q      <= base_d;
      idle_q      <= idle_d;
      bram_we_q   <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
    end
  end

  assign write_ready = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign write_done  = (state_q == StDone);
  assign write_error = (state_q == StErr);
  assign bram_we     = bram_we_q;
  assign bram_addr   = bram_addr_q;
  assign bram_din    = bram_din_q;

endmodule

// File: tb/tb_matrix_store_writer.sv
// Testbench for matrix_store_writer. A transaction-level model predicts, from
// the header and the cycles on which element words are offered, the ordered list
// of BRAM writes, the cycle of the done/error pulse and the busy window. One
// compare process checks the DUT against it every cycle; a few literal checks
// pin the model to hand-computed values.
module tb_matrix_store_writer;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 14;
  localparam int unsigned BS = 1152;
  localparam int unsigned NS = 8;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          write_request;
  logic          write_ready;
  logic [2:0]    write_matrix_id;
  logic [7:0]    write_rows;
  logic [7:0]    write_cols;
  logic [7:0]    write_name [0:7];
  logic [DW-1:0] write_data;
  logic          write_data_valid;
  logic          write_done;
  logic          write_error;
  logic          busy;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;

  always #5 clk = ~clk;

  matrix_store_writer #(
    .BLOCK_SIZE    (BS),
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .NUM_SLOTS     (NS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .write_request   (write_request),
    .write_ready     (write_ready),
    .write_matrix_id (write_matrix_id),
    .write_rows      (write_rows),
    .write_cols      (write_cols),
    .write_name      (write_name),
    .write_data      (write_data),
    .write_data_valid(write_data_valid),
    .write_done      (write_done),
    .write_error     (write_error),
    .busy            (busy),
    .bram_we         (bram_we),
    .bram_addr       (bram_addr),
    .bram_din        (bram_din)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  int  cyc = 0;
  int  nvec = 0;
  int  nfail = 0;
  wr_t exp_q[$];
  wr_t log_q[$];
  bit  done_at[int];
  bit  err_at[int];
  int  busy_from = 1;
  int  busy_to = 0;
  int  we_count = 0;
  int  last_done = -1;
  int  last_err = -1;
  bit  chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    bit  exp_busy;
    wr_t e;
    wr_t o;
    if (chk_en) begin
      exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
      check("busy", busy, exp_busy);
      check("write_ready", write_ready, !exp_busy);
      check("write_done", write_done, done_at.exists(cyc));
      check("write_error", write_error, err_at.exists(cyc));
      if (write_done === 1'b1) last_done = cyc;
      if (write_error === 1'b1) last_err = cyc;
      if (bram_we === 1'b1) begin
        we_count++;
        o.a = bram_addr;
        o.d = bram_din;
        log_q.push_back(o);
        if (exp_q.size() == 0) begin
          check("unexpected bram_we", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("bram_addr", bram_addr, e.a);
          check("bram_din", bram_din, e.d);
        end
      end
    end
  end

  // One transaction: header at cycle r, word k offered at r+start+k*(gap+1),
  // optional stray write_request at r+poke_at. Must be called right after a negedge.
  task automatic xfer(input int id, input int rows, input int cols, input logic [31:0] nm4,
                      input int nwords, input int start, input int gap, input int first_val,
                      input int poke_at, output int r);
    int  t[$];
    int  base, total, acc, idle, k, end_c, dval;
    bit  ok, dv;
    wr_t e;
    r = cyc;
    for (int i = 0; i < nwords; i++) t.push_back(r + start + i * (gap + 1));
    total = rows * cols;
    base  = id * BS;
    ok = (rows != 0) && (cols != 0) && (id < NS) && (total <= BS - 2);
    busy_from = r + 1;
    if (!ok) begin
      err_at[r + 2] = 1'b1;
      busy_to = r + 2;
    end else begin
      acc = 0;
      idle = 0;
      k = 0;
      for (int c = r + 1; c < r + 10000; c++) begin
        dv = (k < nwords) && (t[k] == c);
        if (dv) begin
          k++;
          e.a = AW'(base + 2 + acc);
          e.d = DW'(first_val + k - 1);
          exp_q.push_back(e);
          acc++;
          idle = 0;
          if (acc == total) begin
            e.a = AW'(base);
            e.d = {rows[7:0], cols[7:0], 16'h0000};
            exp_q.push_back(e);
            e.a = AW'(base + 1);
            e.d = nm4;
            exp_q.push_back(e);
            done_at[c + 3] = 1'b1;
            busy_to = c + 3;
            break;
          end
        end else if (c > r + 1) begin
          idle++;
          if (idle == TO) begin
            err_at[c + 1] = 1'b1;
            busy_to = c + 1;
            break;
          end
        end
      end
    end
    end_c = busy_to;
    if (nwords > 0 && t[nwords-1] > end_c) end_c = t[nwords-1];
    if (poke_at >= 0 && r + poke_at > end_c) end_c = r + poke_at;
    end_c += 2;
    for (int c = r; c <= end_c; c++) begin
      write_request = (c == r) || (poke_at >= 0 && c == r + poke_at);
      if (c == r) begin
        write_matrix_id = 3'(id);
        write_rows      = 8'(rows);
        write_cols      = 8'(cols);
        for (int i = 0; i < 4; i++) write_name[i] = nm4[31-8*i -: 8];
        for (int i = 4; i < 8; i++) write_name[i] = 8'h5A;
      end else if (write_request) begin
        write_matrix_id = 3'(id ^ 1);
        write_rows      = 8'd1;
        write_cols      = 8'd1;
      end
      dv = 1'b0;
      dval = 0;
      for (int i = 0; i < nwords; i++) begin
        if (t[i] == c) begin
          dv = 1'b1;
          dval = first_val + i;
        end
      end
      write_data_valid = dv;
      write_data       = DW'(dval);
      @(negedge clk);
    end
    write_request    = 1'b0;
    write_data_valid = 1'b0;
  endtask

  initial begin
    int  r, n0, w0;
    wr_t e;
    rst = 1'b1;
    write_request = 1'b0;
    write_matrix_id = '0;
    write_rows = '0;
    write_cols = '0;
    for (int i = 0; i < 8; i++) write_name[i] = 8'h00;
    write_data = '0;
    write_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset write_ready", write_ready, 1);
    check("reset busy", busy, 0);
    check("reset write_done", write_done, 0);
    check("reset write_error", write_error, 0);
    check("reset bram_we", bram_we, 0);
    check("reset bram_addr", bram_addr, 0);
    check("reset bram_din", bram_din, 0);
    chk_en = 1'b1;

    // ID 1, 2x2, back-to-back from the first STREAM cycle.
    n0 = log_q.size();
    xfer(1, 2, 2, 32'h52455330, 4, 2, 0, 5, -1, r);
    check("t1 write count", log_q.size() - n0, 6);
    if (log_q.size() - n0 == 6) begin
      check("t1 addr0", log_q[n0].a, 1154);
      check("t1 data0", log_q[n0].d, 5);
      check("t1 addr3", log_q[n0+3].a, 1157);
      check("t1 data3", log_q[n0+3].d, 8);
      check("t1 meta0 addr", log_q[n0+4].a, 1152);
      check("t1 meta0 data", log_q[n0+4].d, 32'h02020000);
      check("t1 meta1 addr", log_q[n0+5].a, 1153);
      check("t1 meta1 data", log_q[n0+5].d, 32'h52455330);
    end
    check("t1 done cycle", last_done - r, 8);

    // ID 2, 3x1, words separated by 3 idle cycles.
    n0 = log_q.size();
    xfer(2, 3, 1, 32'h4D415432, 3, 2, 3, 100, -1, r);
    check("t2 write count", log_q.size() - n0, 5);
    if (log_q.size() - n0 == 5) begin
      check("t2 addr first", log_q[n0].a, 2306);
      check("t2 addr last", log_q[n0+2].a, 2308);
      check("t2 meta0", log_q[n0+3].d, 32'h03010000);
    end
    check("t2 done cycle", last_done - r, 13);

    // Rejected headers: rows=0, 34x34 (1156 > 1150), id out of range impossible at 3 bits.
    w0 = we_count;
    xfer(0, 0, 3, 32'h41414141, 0, 2, 0, 0, -1, r);
    check("t3a error cycle", last_err - r, 2);
    xfer(1, 34, 34, 32'h42424242, 0, 2, 0, 0, -1, r);
    check("t3b error cycle", last_err - r, 2);
    check("t3 no writes", we_count - w0, 0);
    check("t3 ready again", write_ready, 1);

    // Timeout: 2x2 with only 2 words.
    n0 = log_q.size();
    xfer(1, 2, 2, 32'h544D4F54, 2, 2, 0, 20, -1, r);
    check("t4 error cycle", last_err - r, 20);
    check("t4 write count", log_q.size() - n0, 2);

    // Reset mid-STREAM after one word.
    r = cyc;
    busy_from = r + 1;
    busy_to = r + 3;
    e.a = AW'(1154);
    e.d = 32'hAA;
    exp_q.push_back(e);
    write_request = 1'b1;
    write_matrix_id = 3'd1;
    write_rows = 8'd2;
    write_cols = 8'd2;
    @(negedge clk);
    write_request = 1'b0;
    @(negedge clk);
    write_data_valid = 1'b1;
    write_data = 32'hAA;
    @(negedge clk);
    write_data_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst mid bram_we", bram_we, 0);
    check("rst mid bram_addr", bram_addr, 0);
    check("rst mid bram_din", bram_din, 0);
    check("rst mid ready", write_ready, 1);
    check("rst mid busy", busy, 0);
    @(negedge clk);
    // New request completes normally, first word offered during CHECK.
    xfer(3, 2, 2, 32'h4E455731, 4, 1, 0, 40, -1, r);
    check("t5 done cycle", last_done - r, 7);

    // Extra fifth word and a stray request during STREAM are ignored.
    w0 = we_count;
    xfer(1, 2, 2, 32'h45585452, 5, 2, 0, 60, 3, r);
    check("t6 bram_we pulses", we_count - w0, 6);
    check("t6 done cycle", last_done - r, 8);

    repeat (5) @(negedge clk);
    check("pending expected writes", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
